// File: rtl/sd_sector_sequencer.sv
// Multi-sector read sequencer: owns the sd_interface register port, passes the CPU through
// while idle, and streams COUNT sectors of 512 bytes from LBA into RAM at DST.
module sd_sector_sequencer #(
    parameter int TIMEOUT = 65535,
    parameter int CNT_W   = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [31:0]      lba_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic [15:0]      dst_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    input  logic             cpu_sd_cs_i,
    input  logic             cpu_R_W_n_i,
    input  logic [7:0]       cpu_reg_addr_i,
    input  logic [7:0]       cpu_data_i,
    output logic [7:0]       cpu_data_o,
    output logic             sd_cs_o,
    output logic             sd_R_W_n_o,
    output logic [7:0]       sd_reg_addr_o,
    output logic [7:0]       sd_wdata_o,
    input  logic [7:0]       sd_rdata_i,
    output logic             mem_we_o,
    output logic [15:0]      mem_addr_o,
    output logic [7:0]       mem_data_o
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CHKIDLE, S_SETADDR, S_START, S_WAITHI,
        S_WAITLO, S_PAGE, S_COPY, S_FINISH, S_DONE
    } state_t;

    state_t            state_r, state_nx_s;
    logic [31:0]       lba_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [15:0]       ptr_r;
    logic [1:0]        page_r;
    logic [6:0]        idx_r;
    logic [TW-1:0]     tmo_r;
    logic              busy_r, done_r, err_r, mem_we_r;
    logic [15:0]       mem_addr_r;
    logic [7:0]        mem_data_r;
    logic              seq_cs_s, seq_rw_s;
    logic [7:0]        seq_addr_s, seq_wdata_s;
    logic              tmo_hit_s, idle_s;

    assign tmo_hit_s = (tmo_r == TW'(TIMEOUT - 1));
    assign idle_s    = (state_r == S_IDLE);

    assign sd_cs_o       = idle_s ? cpu_sd_cs_i    : seq_cs_s;
    assign sd_R_W_n_o    = idle_s ? cpu_R_W_n_i    : seq_rw_s;
    assign sd_reg_addr_o = idle_s ? cpu_reg_addr_i : seq_addr_s;
    assign sd_wdata_o    = idle_s ? cpu_data_i     : seq_wdata_s;
    assign cpu_data_o    = idle_s ? sd_rdata_i     : 8'h00;

    assign busy_o     = busy_r;
    assign done_o     = done_r;
    assign err_o      = err_r;
    assign mem_we_o   = mem_we_r;
    assign mem_addr_o = mem_addr_r;
    assign mem_data_o = mem_data_r;

    // Next-state decode and sequencer-side register access for the current cycle
    always_comb begin
        state_nx_s  = state_r;
        seq_cs_s    = 1'b0;
        seq_rw_s    = 1'b1;
        seq_addr_s  = 8'h00;
        seq_wdata_s = 8'h00;
        case (state_r)
            S_IDLE: begin
                if (start_i) begin
                    state_nx_s = (count_i == '0) ? S_FINISH : S_CHKIDLE;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_CHKIDLE: begin
                seq_cs_s   = 1'b1;
                seq_addr_s = 8'h04;
                if (!sd_rdata_i[0])  state_nx_s = S_SETADDR;
                else if (tmo_hit_s)  state_nx_s = S_FINISH;
                else                 state_nx_s = S_CHKIDLE;
            end
            S_SETADDR: begin
                seq_cs_s    = 1'b1;
                seq_rw_s    = 1'b0;
                seq_addr_s  = {6'b000000, idx_r[1:0]};
                seq_wdata_s = lba_r[{idx_r[1:0], 3'b000} +: 8];
                if (idx_r[1:0] == 2'd3) state_nx_s = S_START;
                else                    state_nx_s = S_SETADDR;
            end
            S_START: begin
                seq_cs_s   = 1'b1;
                seq_rw_s   = 1'b0;
                seq_addr_s = 8'h05;
                state_nx_s = S_WAITHI;
            end
            S_WAITHI: begin
                seq_cs_s   = 1'b1;
                seq_addr_s = 8'h04;
                if (sd_rdata_i[0])   state_nx_s = S_WAITLO;
                else if (tmo_hit_s)  state_nx_s = S_FINISH;
                else                 state_nx_s = S_WAITHI;
            end
            S_WAITLO: begin
                seq_cs_s   = 1'b1;
                seq_addr_s = 8'h04;
                if (!sd_rdata_i[0])  state_nx_s = S_PAGE;
                else if (tmo_hit_s)  state_nx_s = S_FINISH;
                else                 state_nx_s = S_WAITLO;
            end
            S_PAGE: begin
                seq_cs_s    = 1'b1;
                seq_rw_s    = 1'b0;
                seq_addr_s  = 8'h07;
                seq_wdata_s = {6'b000000, page_r};
                state_nx_s  = S_COPY;
            end
            S_COPY: begin
                seq_cs_s   = 1'b1;
                seq_addr_s = {1'b1, idx_r};
                if (idx_r != 7'd127)            state_nx_s = S_COPY;
                else if (page_r != 2'd3)        state_nx_s = S_PAGE;
                else if (cnt_r == CNT_W'(1))    state_nx_s = S_FINISH;
                else                            state_nx_s = S_SETADDR;
            end
            // FINISH lets the final RAM write land before done_o is raised
            S_FINISH: state_nx_s = S_DONE;
            S_DONE:   state_nx_s = S_IDLE;
            default:  state_nx_s = S_IDLE;
        endcase
    end

    // State register, job registers and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= S_IDLE;
            lba_r      <= 32'h0000_0000;
            cnt_r      <= '0;
            ptr_r      <= 16'h0000;
            page_r     <= 2'd0;
            idx_r      <= 7'd0;
            tmo_r      <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            mem_we_r   <= 1'b0;
            mem_addr_r <= 16'h0000;
            mem_data_r <= 8'h00;
        end else begin
            state_r  <= state_nx_s;
            busy_r   <= (state_nx_s != S_IDLE);
            done_r   <= (state_nx_s == S_DONE);
            mem_we_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start_i) begin
                        lba_r <= lba_i;
                        cnt_r <= count_i;
                        ptr_r <= dst_i;
                        err_r <= 1'b0;
                        tmo_r <= '0;
                    end
                end
                S_CHKIDLE: begin
                    if (!sd_rdata_i[0])  idx_r <= 7'd0;
                    else if (tmo_hit_s)  err_r <= 1'b1;
                    else                 tmo_r <= tmo_r + TW'(1);
                end
                S_SETADDR: idx_r <= idx_r + 7'd1;
                S_START:   tmo_r <= '0;
                S_WAITHI: begin
                    if (sd_rdata_i[0])   tmo_r <= '0;
                    else if (tmo_hit_s)  err_r <= 1'b1;
                    else                 tmo_r <= tmo_r + TW'(1);
                end
                S_WAITLO: begin
                    if (!sd_rdata_i[0])  page_r <= 2'd0;
                    else if (tmo_hit_s)  err_r  <= 1'b1;
                    else                 tmo_r  <= tmo_r + TW'(1);
                end
                S_PAGE: idx_r <= 7'd0;
                S_COPY: begin
                    mem_we_r   <= 1'b1;
                    mem_data_r <= sd_rdata_i;
                    mem_addr_r <= ptr_r;
                    ptr_r      <= ptr_r + 16'd1;
                    idx_r      <= idx_r + 7'd1;
                    if (idx_r == 7'd127) begin
                        if (page_r != 2'd3) begin
                            page_r <= page_r + 2'd1;
                        end else begin
                            lba_r <= lba_r + 32'd1;
                            cnt_r <= cnt_r - CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_sector_sequencer.sv
// Bench for sd_sector_sequencer: an sd_interface register model plus a transaction-level
// reference of the expected RAM writes and register writes for each job.
module tb_sd_sector_sequencer;

    localparam int CNT_W = 8;
    localparam int TMO   = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_i = 1'b1;
    logic             start_i = 1'b0;
    logic [31:0]      lba_i = 32'h0;
    logic [CNT_W-1:0] count_i = '0;
    logic [15:0]      dst_i = 16'h0;
    logic             busy_o, done_o, err_o;
    logic             cpu_sd_cs_i = 1'b0, cpu_R_W_n_i = 1'b1;
    logic [7:0]       cpu_reg_addr_i = 8'h00, cpu_data_i = 8'h00, cpu_data_o;
    logic             sd_cs_o, sd_R_W_n_o;
    logic [7:0]       sd_reg_addr_o, sd_wdata_o, sd_rdata_i;
    logic             mem_we_o;
    logic [15:0]      mem_addr_o;
    logic [7:0]       mem_data_o;

    sd_sector_sequencer #(.TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .lba_i(lba_i), .count_i(count_i),
        .dst_i(dst_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .cpu_sd_cs_i(cpu_sd_cs_i), .cpu_R_W_n_i(cpu_R_W_n_i), .cpu_reg_addr_i(cpu_reg_addr_i),
        .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .sd_cs_o(sd_cs_o),
        .sd_R_W_n_o(sd_R_W_n_o), .sd_reg_addr_o(sd_reg_addr_o), .sd_wdata_o(sd_wdata_o),
        .sd_rdata_i(sd_rdata_i), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o)
    );

    int checks = 0;
    int errors = 0;

    // Sector contents served by the model: byte b of sector l
    function automatic logic [7:0] sector_byte(input logic [31:0] l, input int b);
        logic [31:0] t;
        t = l * 32'd3 + b;
        return t[7:0];
    endfunction

    // ---------------- sd_interface register model ----------------
    logic [7:0]  mreg [0:7];
    logic [1:0]  mpage = 2'd0;
    logic [31:0] slba = 32'h0;
    logic        mbusy = 1'b0;
    logic        pending = 1'b0;
    logic        hang = 1'b0;
    int          pre_cnt = 0, hold_cnt = 0;

    initial for (int i = 0; i < 8; i++) mreg[i] = 8'h00;

    always @(posedge clk) begin
        if (sd_cs_o && !sd_R_W_n_o) begin
            if (sd_reg_addr_o < 8'h08) mreg[sd_reg_addr_o[2:0]] <= sd_wdata_o;
            if (sd_reg_addr_o == 8'h07) mpage <= sd_wdata_o[1:0];
            if (sd_reg_addr_o == 8'h05) begin
                slba     <= {mreg[3], mreg[2], mreg[1], mreg[0]};
                pending  <= 1'b1;
                pre_cnt  <= $urandom_range(0, 3);
                hold_cnt <= $urandom_range(1, 6);
            end
        end else if (pending) begin
            if (pre_cnt > 0)        pre_cnt <= pre_cnt - 1;
            else if (!mbusy)        mbusy <= 1'b1;
            else if (hold_cnt > 0)  hold_cnt <= hold_cnt - 1;
            else begin
                mbusy   <= 1'b0;
                pending <= 1'b0;
            end
        end
    end

    always_comb begin
        sd_rdata_i = 8'h00;
        if (sd_reg_addr_o[7])            sd_rdata_i = sector_byte(slba, int'({mpage, sd_reg_addr_o[6:0]}));
        else if (sd_reg_addr_o == 8'h04) sd_rdata_i = {7'b0000000, mbusy | hang};
        else if (sd_reg_addr_o < 8'h08)  sd_rdata_i = mreg[sd_reg_addr_o[2:0]];
        else                             sd_rdata_i = 8'h00;
    end

    // ---------------- transaction monitor ----------------
    logic [23:0] mem_q [$];
    logic [15:0] wr_q [$];
    int done_cnt = 0;
    int poll_cnt = 0;

    always @(posedge clk) begin
        if (mem_we_o) mem_q.push_back({mem_addr_o, mem_data_o});
        if (sd_cs_o && !sd_R_W_n_o) wr_q.push_back({sd_reg_addr_o, sd_wdata_o});
        if (sd_cs_o && sd_R_W_n_o && sd_reg_addr_o == 8'h04 && busy_o) poll_cnt++;
        if (done_o) done_cnt++;
    end

    task automatic clear_logs();
        mem_q.delete();
        wr_q.delete();
        done_cnt = 0;
        poll_cnt = 0;
    endtask

    task automatic pulse_start(input logic [31:0] lba, input int cnt, input logic [15:0] dst);
        lba_i   = lba;
        count_i = CNT_W'(cnt);
        dst_i   = dst;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Runs a full job and compares every RAM and register write against the reference
    task automatic run_job(input string name, input logic [31:0] lba, input int cnt,
                           input logic [15:0] dst, input bit cpu_poke);
        logic [15:0] exp_wr [$];
        logic [31:0] sl;
        logic [15:0] ea;
        int bad;
        int c;
        clear_logs();
        pulse_start(lba, cnt, dst);
        checks++;
        if (busy_o !== 1'b1 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL %s busy/err after start got %b/%b exp 1/0", name, busy_o, err_o);
        end
        if (cpu_poke) begin
            cpu_sd_cs_i = 1'b1; cpu_R_W_n_i = 1'b0; cpu_reg_addr_i = 8'h06; cpu_data_i = 8'hA5;
        end
        c = 0;
        while (done_cnt == 0 && c < 2000 * cnt + 200) begin
            @(negedge clk);
            c++;
            if (cpu_poke && c == 50) begin
                checks++;
                if (cpu_data_o !== 8'h00) begin
                    errors++;
                    $display("FAIL %s cpu_data_o while busy got %h exp 00", name, cpu_data_o);
                end
                cpu_R_W_n_i = 1'b1; cpu_reg_addr_i = 8'h00;
            end
        end
        cpu_sd_cs_i = 1'b0; cpu_R_W_n_i = 1'b1; cpu_reg_addr_i = 8'h00; cpu_data_i = 8'h00;
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL %s done timeout after %0d cycles", name, c);
        end
        @(negedge clk);
        checks++;
        if (done_cnt !== 1 || busy_o !== 1'b0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL %s end state done_cnt=%0d busy=%b err=%b exp 1/0/0", name, done_cnt, busy_o, err_o);
        end
        checks++;
        if (mem_q.size() != cnt * 512) begin
            errors++;
            $display("FAIL %s mem write count got %0d exp %0d", name, mem_q.size(), cnt * 512);
        end else begin
            bad = -1;
            for (int i = 0; i < cnt * 512; i++) begin
                sl = lba + 32'(i / 512);
                ea = dst + 16'(i);
                if (bad < 0 && mem_q[i] !== {ea, sector_byte(sl, i % 512)}) bad = i;
            end
            checks++;
            if (bad >= 0) begin
                errors++;
                $display("FAIL %s mem write %0d got %h exp %h", name, bad, mem_q[bad],
                         {dst + 16'(bad), sector_byte(lba + 32'(bad / 512), bad % 512)});
            end
        end
        for (int s = 0; s < cnt; s++) begin
            sl = lba + 32'(s);
            for (int k = 0; k < 4; k++) exp_wr.push_back({8'(k), sl[8*k +: 8]});
            exp_wr.push_back({8'h05, 8'h00});
            for (int p = 0; p < 4; p++) exp_wr.push_back({8'h07, 8'(p)});
        end
        checks++;
        if (wr_q.size() != exp_wr.size()) begin
            errors++;
            $display("FAIL %s reg write count got %0d exp %0d", name, wr_q.size(), exp_wr.size());
        end else begin
            bad = -1;
            for (int i = 0; i < exp_wr.size(); i++) begin
                if (bad < 0 && (wr_q[i][15:8] !== exp_wr[i][15:8] ||
                    (exp_wr[i][15:8] != 8'h05 && wr_q[i][7:0] !== exp_wr[i][7:0]))) bad = i;
            end
            checks++;
            if (bad >= 0) begin
                errors++;
                $display("FAIL %s reg write %0d got %h exp %h", name, bad, wr_q[bad], exp_wr[bad]);
            end
        end
    endtask

    task automatic test_reset();
        cpu_sd_cs_i = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_o, done_o, err_o, mem_we_o} !== 4'b0000 || mem_addr_o !== 16'h0000 ||
            mem_data_o !== 8'h00 || sd_cs_o !== 1'b1) begin
            errors++;
            $display("FAIL reset outputs got b%b d%b e%b we%b a%h d%h cs%b exp 0 0 0 0 0000 00 1",
                     busy_o, done_o, err_o, mem_we_o, mem_addr_o, mem_data_o, sd_cs_o);
        end
        cpu_sd_cs_i = 1'b0;
        rst_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_cpu_mux();
        cpu_sd_cs_i = 1'b1; cpu_R_W_n_i = 1'b0; cpu_reg_addr_i = 8'h00; cpu_data_i = 8'h5A;
        @(negedge clk);
        cpu_R_W_n_i = 1'b1;
        #1;
        checks++;
        if (mreg[0] !== 8'h5A || cpu_data_o !== 8'h5A) begin
            errors++;
            $display("FAIL cpu_mux reg00 got %h readback %h exp 5A", mreg[0], cpu_data_o);
        end
        cpu_sd_cs_i = 1'b0; cpu_data_i = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_count_zero();
        clear_logs();
        pulse_start(32'h1234_5678, 0, 16'h1000);
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL count0 cycle1 done/busy got %b/%b exp 0/1", done_o, busy_o);
        end
        @(negedge clk);
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL count0 done pulse got %b exp 1", done_o);
        end
        @(negedge clk);
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || wr_q.size() != 0 || mem_q.size() != 0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL count0 after done=%b busy=%b wr=%0d mem=%0d err=%b exp 0 0 0 0 0",
                     done_o, busy_o, wr_q.size(), mem_q.size(), err_o);
        end
    endtask

    task automatic test_two_sectors();
        run_job("two_sectors", 32'h0000_00FF, 2, 16'h4000, 1'b1);
        checks++;
        if (wr_q.size() < 13 || wr_q[0][7:0] !== 8'hFF || wr_q[10][7:0] !== 8'h01) begin
            errors++;
            $display("FAIL two_sectors lba bytes got %0d entries exp FF at 0 and 01 at 10", wr_q.size());
        end
    endtask

    task automatic test_wrap();
        run_job("wrap", 32'h0000_0200, 1, 16'hFF80, 1'b0);
        checks++;
        if (mem_q.size() < 512 || mem_q[128][23:8] !== 16'h0000 || mem_q[511][23:8] !== 16'h017F) begin
            errors++;
            $display("FAIL wrap addresses size=%0d exp 0000 at 128 and 017F at 511", mem_q.size());
        end
    endtask

    task automatic test_timeout();
        int c;
        clear_logs();
        hang = 1'b1;
        pulse_start(32'h0000_0042, 1, 16'h0000);
        c = 0;
        while (done_cnt == 0 && c < 1000) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (done_cnt != 1 || err_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout end done_cnt=%0d err=%b busy=%b exp 1 1 0", done_cnt, err_o, busy_o);
        end
        checks++;
        if (poll_cnt != TMO || wr_q.size() != 0 || mem_q.size() != 0) begin
            errors++;
            $display("FAIL timeout polls got %0d writes %0d mem %0d exp %0d 0 0",
                     poll_cnt, wr_q.size(), mem_q.size(), TMO);
        end
        hang = 1'b0;
        run_job("after_timeout", 32'h0000_0043, 1, 16'h0800, 1'b0);
    endtask

    task automatic test_random();
        for (int j = 0; j < 3; j++) begin
            run_job("random", $urandom, $urandom_range(1, 3), 16'($urandom), 1'b0);
        end
    endtask

    task automatic test_reset_mid_copy();
        int c;
        int n;
        clear_logs();
        pulse_start(32'h0000_0077, 2, 16'h3000);
        c = 0;
        while (mem_q.size() < 100 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || mem_we_o !== 1'b0 || sd_cs_o !== 1'b0 || mem_q.size() < 100) begin
            errors++;
            $display("FAIL rst_mid_copy state busy=%b we=%b cs=%b mem=%0d exp 0 0 0 >=100",
                     busy_o, mem_we_o, sd_cs_o, mem_q.size());
        end
        n = mem_q.size();
        repeat (600) @(negedge clk);
        checks++;
        if (done_cnt != 0 || mem_q.size() != n) begin
            errors++;
            $display("FAIL rst_mid_copy after done_cnt=%0d mem=%0d exp 0 %0d", done_cnt, mem_q.size(), n);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_mux();
        test_count_zero();
        run_job("one_sector", 32'h0000_0010, 1, 16'h2000, 1'b0);
        test_two_sectors();
        test_wrap();
        test_timeout();
        test_random();
        test_reset_mid_copy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
